// File: rtl/constants.sv
// Shared limits for the multi-channel clock divider.
package constants;

    localparam int unsigned MAX_CHANNELS = 16;
    localparam int unsigned MAX_WIDTH    = 32;

endpackage

// File: rtl/wires.sv
// Per-channel divider state, held at the widest supported divisor width.
package wires;

    import constants::*;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] count;
        logic [MAX_WIDTH-1:0] active;
        logic [MAX_WIDTH-1:0] pend_div;
        logic                 pend;
    } chan_state_t;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, active/pending divisor and clock toggle.
module clk_div_chan
    import constants::*;
    import wires::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned RESET_DIV = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_div,
    input  logic             enable,
    output logic             clock_per,
    output logic             tick,
    output logic             pending
);

    localparam int unsigned MW = MAX_WIDTH;

    chan_state_t st_q, st_d;
    logic        clk_q, clk_d;
    logic        tick_q, tick_d;

    // Next-state: stopped channels pick up a pending divisor at once,
    // running ones only at the falling wrap so no half-period is cut.
    always_comb begin
        st_d   = st_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        if (st_q.active == '0) begin
            clk_d      = 1'b0;
            st_d.count = '0;
            if (st_q.pend) begin
                st_d.active = st_q.pend_div;
                st_d.pend   = 1'b0;
            end
        end else if (enable) begin
            if (st_q.count == st_q.active - MW'(1)) begin
                st_d.count = '0;
                clk_d      = ~clk_q;
                tick_d     = ~clk_q;
                if (clk_q && st_q.pend) begin
                    st_d.active = st_q.pend_div;
                    st_d.pend   = 1'b0;
                end
            end else begin
                st_d.count = st_q.count + MW'(1);
            end
        end
        // Writes are only accepted while nothing is pending, so no apply can collide.
        if (wr_en) begin
            st_d.pend_div = MW'(wr_div);
            st_d.pend     = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st_q.count    <= '0;
            st_q.active   <= MW'(WIDTH'(RESET_DIV));
            st_q.pend_div <= '0;
            st_q.pend     <= 1'b0;
            clk_q         <= 1'b0;
            tick_q        <= 1'b0;
        end else begin
            st_q   <= st_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign clock_per = clk_q;
    assign tick      = tick_q;
    assign pending   = st_q.pend;

endmodule

// File: rtl/clk_div_multi.sv
// Bank of independent programmable clock dividers sharing one write port.
module clk_div_multi
    import constants::*;
#(
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned RESET_DIV = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_chan,
    input  logic [WIDTH-1:0]    cfg_div,
    input  logic [CHANNELS-1:0] enable,
    output logic [CHANNELS-1:0] clock_per,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pending
);

    localparam int unsigned CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    if (CHANNELS == 0 || CHANNELS > MAX_CHANNELS || WIDTH == 0 || WIDTH > MAX_WIDTH) begin : g_bad_cfg
        $error("clk_div_multi: unsupported CHANNELS/WIDTH");
    end

    // Ready only for an existing channel with no divisor already waiting.
    always_comb begin
        cfg_ready = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (CHAN_W'(i) == cfg_chan) begin
                cfg_ready = ~pending[i];
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic wr_en;

        assign wr_en = cfg_valid && cfg_ready && (cfg_chan == CHAN_W'(g));

        clk_div_chan #(
            .WIDTH     (WIDTH),
            .RESET_DIV (RESET_DIV)
        ) u_chan (
            .clock     (clock),
            .reset     (reset),
            .wr_en     (wr_en),
            .wr_div    (cfg_div),
            .enable    (enable[g]),
            .clock_per (clock_per[g]),
            .tick      (tick[g]),
            .pending   (pending[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: waveforms recorded per cycle and compared to hand-built patterns.
module tb_clk_div_multi;

    logic        clock;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [0:0]  cfg_chan;
    logic [15:0] cfg_div;
    logic [1:0]  enable;
    logic [1:0]  clock_per;
    logic [1:0]  tick;
    logic [1:0]  pending;

    int n_tests;
    int n_fail;

    logic [31:0] cp0_v, cp1_v, tk0_v, tk1_v, pd0_v, pd1_v;

    clk_div_multi #(
        .CHANNELS  (2),
        .WIDTH     (16),
        .RESET_DIV (0)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_div   (cfg_div),
        .enable    (enable),
        .clock_per (clock_per),
        .tick      (tick),
        .pending   (pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Half-period pattern starting high at cycle 'start', limited to cycles 0..n-1.
    function automatic logic [31:0] wave(input int start, input int hi, input int lo, input int n);
        logic [31:0] w;
        w = '0;
        for (int k = start; k < n; k++) begin
            if (((k - start) % (hi + lo)) < hi) w[k] = 1'b1;
        end
        return w;
    endfunction

    task automatic clear_trace();
        cp0_v = '0; cp1_v = '0; tk0_v = '0; tk1_v = '0; pd0_v = '0; pd1_v = '0;
    endtask

    task automatic drive(input logic v, input logic [0:0] ch, input logic [15:0] d);
        cfg_valid = v;
        cfg_chan  = ch;
        cfg_div   = d;
    endtask

    // Advance one edge and record the outputs for cycle k.
    task automatic step(input int k);
        @(posedge clock);
        @(negedge clock);
        cp0_v[k] = clock_per[0];
        cp1_v[k] = clock_per[1];
        tk0_v[k] = tick[0];
        tk1_v[k] = tick[1];
        pd0_v[k] = pending[0];
        pd1_v[k] = pending[1];
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #23;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b0;
        enable    = 2'b11;
        drive(1'b0, 1'b0, 16'd0);
        #12;
        chk("rst_clock_per", 32'(clock_per), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        do_reset();
        #1;
        chk("idle_ready", 32'(cfg_ready), 32'h1);

        // Stopped ch0 gets N=3: first rise four edges after the write, period 6.
        clear_trace();
        for (int k = 0; k <= 16; k++) begin
            if (k == 0) drive(1'b1, 1'b0, 16'd3);
            else        drive(1'b0, 1'b0, 16'd0);
            step(k);
        end
        chk("n3_wave", cp0_v, wave(4, 3, 3, 17));
        chk("n3_tick", tk0_v, 32'h0001_0410);
        chk("n3_pend", pd0_v, 32'h0000_0001);
        chk("n3_ch1_idle", cp1_v | tk1_v, 32'h0);

        // Retarget N=4 -> N=2 during the high phase; switch happens at the falling wrap.
        do_reset();
        clear_trace();
        for (int k = 0; k <= 20; k++) begin
            if (k == 0)      drive(1'b1, 1'b0, 16'd4);
            else if (k == 6) drive(1'b1, 1'b0, 16'd2);
            else             drive(1'b0, 1'b0, 16'd0);
            step(k);
        end
        chk("retgt_wave", cp0_v, 32'h0019_99E0);
        chk("retgt_tick", tk0_v, 32'h0008_8820);
        chk("retgt_pend", pd0_v, 32'h0000_01C1);

        // Back-pressure on a pending channel, ch1 accepted, ch1 frozen 7 cycles, ch0 undisturbed.
        do_reset();
        clear_trace();
        for (int k = 0; k <= 30; k++) begin
            if (k == 0) drive(1'b1, 1'b0, 16'd3);
            else if (k == 1) begin
                drive(1'b1, 1'b0, 16'd7);
                #1;
                chk("busy_ready", 32'(cfg_ready), 32'h0);
            end else if (k == 2) begin
                drive(1'b1, 1'b1, 16'd5);
                #1;
                chk("ch1_ready", 32'(cfg_ready), 32'h1);
            end else if (k == 29) drive(1'b1, 1'b0, 16'd6);
            else drive(1'b0, 1'b0, 16'd0);
            enable[1] = !(k >= 10 && k <= 16);
            step(k);
        end
        enable = 2'b11;
        chk("busy_pend0", pd0_v, 32'h6000_0001);
        chk("ch1_pend", pd1_v, 32'h0000_0004);
        chk("ch0_wave", cp0_v, wave(4, 3, 3, 31));
        chk("frz_wave", cp1_v, 32'h3E0F_FF00);
        chk("frz_tick", tk1_v, 32'h0200_0100);

        // Asynchronous reset while ch0 is high with a divisor pending.
        chk("pre_rst_state", {30'd0, clock_per[0], pending[0]}, 32'h3);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_cp", 32'(clock_per), 32'h0);
        chk("async_rst_pend", 32'(pending), 32'h0);
        chk("async_rst_tick", 32'(tick), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        clear_trace();
        for (int k = 0; k <= 9; k++) begin
            drive(1'b0, 1'b0, 16'd0);
            step(k);
        end
        chk("post_rst_cp", cp0_v | cp1_v, 32'h0);
        chk("post_rst_pend", pd0_v | pd1_v, 32'h0);

        // N=2, stop with N=0 at the next falling wrap, then N=1 toggles every cycle.
        clear_trace();
        for (int k = 0; k <= 20; k++) begin
            if (k == 0)       drive(1'b1, 1'b0, 16'd2);
            else if (k == 4)  drive(1'b1, 1'b0, 16'd0);
            else if (k == 10) drive(1'b1, 1'b0, 16'd1);
            else              drive(1'b0, 1'b0, 16'd0);
            step(k);
        end
        chk("stop_n1_wave", cp0_v, 32'h0015_5018);
        chk("stop_n1_tick", tk0_v, 32'h0015_5008);
        chk("stop_n1_pend", pd0_v, 32'h0000_0411);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
